step_pulse_debouncer: RTL

STEP_PULSE_DEBOUNCER -- requirements
Module: step_pulse_debouncer

---
 rtl/debounce_pkg.sv | 40 ++++
 rtl/step_pulse_debouncer_if.sv | 15 +
 rtl/sync_2ff.sv | 25 ++
 rtl/step_pulse_debouncer.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// Shared constants for the push-button debouncer/divider family.
// Holds the 3-bit FSM state encodings, the state enum built on them,
// the default timing parameters and small constant helpers.
package debounce_pkg;

    localparam logic [2:0] ST_IDLE         = 3'd0;
    localparam logic [2:0] ST_PRESS_WAIT   = 3'd1;
    localparam logic [2:0] ST_PRESSED      = 3'd2;
    localparam logic [2:0] ST_REPEAT       = 3'd3;
    localparam logic [2:0] ST_RELEASE_WAIT = 3'd4;

    typedef enum logic [2:0] {
        IDLE         = ST_IDLE,
        PRESS_WAIT   = ST_PRESS_WAIT,
        PRESSED      = ST_PRESSED,
        REPEAT       = ST_REPEAT,
        RELEASE_WAIT = ST_RELEASE_WAIT
    } db_state_e;

    localparam int unsigned DEF_DB_CYCLES     = 500_000;
    localparam int unsigned DEF_HOLD_CYCLES   = 50_000_000;
    localparam int unsigned DEF_REPEAT_CYCLES = 10_000_000;
    localparam bit          DEF_REPEAT_EN     = 1'b1;

    // Largest of three timing constants; sizes the shared counter.
    function automatic int unsigned max3(input int unsigned a,
                                         input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Terminal count for a periodic step timer. Periods below 2 are
    // stretched to 2 so two step pulses can never be adjacent.
    function automatic int unsigned period_term(input int unsigned period);
        return (period < 2) ? 1 : period - 1;
    endfunction

endpackage

// File: rtl/step_pulse_debouncer_if.sv
// Button-side signal bundle of the step pulse debouncer.
//   btn_raw   : raw, asynchronous, bouncing button level (1 = pressed)
//   step      : one-cycle step pulse (count enable for the downstream counter)
//   btn_db    : debounced button level
//   repeating : high while auto-repeat is active
// master drives btn_raw and observes the results; slave is the debouncer.
interface step_pulse_debouncer_if;
    logic btn_raw;
    logic step;
    logic btn_db;
    logic repeating;

    modport master (output btn_raw, input step, input btn_db, input repeating);
    modport slave  (input btn_raw, output step, output btn_db, output repeating);
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
//   clk  : destination clock
//   RSTN : asynchronous active-low reset, both flops clear to 0
//   d    : asynchronous input
//   q    : synchronized output, two clk edges of latency
module sync_2ff (
    input  logic clk,
    input  logic RSTN,
    input  logic d,
    output logic q
);

    logic meta_q;

    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            meta_q <= 1'b0;
            q      <= 1'b0;
        end else begin
            meta_q <= d;
            q      <= meta_q;
        end
    end

endmodule

// File: rtl/step_pulse_debouncer.sv
// Debounces a push button and turns each accepted press into a one-cycle
// step pulse, with optional auto-repeat while the button stays held.
//   clk  : sole clock, rising edge
//   RSTN : asynchronous active-low reset
//   bus  : slave side of step_pulse_debouncer_if (btn_raw in;
//          step, btn_db, repeating out, all registered)
// A press is accepted once DB_CYCLES consecutive synchronized samples read 1
// (the sample that leaves IDLE counts as the first), so the step appears in
// the cycle after edge DB_CYCLES+2 of a clean press; release is symmetric.
module step_pulse_debouncer
    import debounce_pkg::*;
#(
    parameter int unsigned DB_CYCLES     = DEF_DB_CYCLES,
    parameter int unsigned HOLD_CYCLES   = DEF_HOLD_CYCLES,
    parameter int unsigned REPEAT_CYCLES = DEF_REPEAT_CYCLES,
    parameter bit          REPEAT_EN     = DEF_REPEAT_EN
) (
    input  logic                   clk,
    input  logic                   RSTN,
    step_pulse_debouncer_if.slave  bus
);

    localparam int unsigned CNT_W =
        $clog2(max3(DB_CYCLES, HOLD_CYCLES, REPEAT_CYCLES)) + 1;

    localparam logic [CNT_W-1:0] DB_TERM   = CNT_W'(DB_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_TERM = CNT_W'(period_term(HOLD_CYCLES));
    localparam logic [CNT_W-1:0] REP_TERM  = CNT_W'(period_term(REPEAT_CYCLES));
    localparam bit               DB_ONE    = (DB_CYCLES <= 1);

    logic             s;
    db_state_e        state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             step_q, step_d;
    logic             btn_db_q, btn_db_d;
    logic             repeating_q, repeating_d;

    sync_2ff u_sync (
        .clk  (clk),
        .RSTN (RSTN),
        .d    (bus.btn_raw),
        .q    (s)
    );

    // State and output registers.
    always_ff @(posedge clk or negedge RSTN) begin
        if (!RSTN) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            step_q      <= 1'b0;
            btn_db_q    <= 1'b0;
            repeating_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            step_q      <= step_d;
            btn_db_q    <= btn_db_d;
            repeating_q <= repeating_d;
        end
    end

    // Next-state, shared counter and output decode.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        step_d   = 1'b0;
        btn_db_d = btn_db_q;

        case (state_q)
            IDLE: begin
                if (s) begin
                    if (DB_ONE) begin
                        state_d  = PRESSED;
                        cnt_d    = '0;
                        step_d   = 1'b1;
                        btn_db_d = 1'b1;
                    end else begin
                        state_d = PRESS_WAIT;
                        cnt_d   = CNT_W'(1);
                    end
                end
            end

            PRESS_WAIT: begin
                if (!s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DB_TERM) begin
                    state_d  = PRESSED;
                    cnt_d    = '0;
                    step_d   = 1'b1;
                    btn_db_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            PRESSED, REPEAT: begin
                if (!s) begin
                    if (DB_ONE) begin
                        state_d  = IDLE;
                        cnt_d    = '0;
                        btn_db_d = 1'b0;
                    end else begin
                        state_d = RELEASE_WAIT;
                        cnt_d   = CNT_W'(1);
                    end
                end else if (state_q == PRESSED) begin
                    if (REPEAT_EN && (cnt_q == HOLD_TERM)) begin
                        state_d = REPEAT;
                        cnt_d   = '0;
                        step_d  = 1'b1;
                    end else if (cnt_q != HOLD_TERM) begin
                        // Saturates at the hold terminal when repeat is off.
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (cnt_q == REP_TERM) begin
                    cnt_d  = '0;
                    step_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            RELEASE_WAIT: begin
                if (s) begin
                    // Release was a glitch: back to held, hold timer restarts.
                    state_d = PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == DB_TERM) begin
                    state_d  = IDLE;
                    cnt_d    = '0;
                    btn_db_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_d  = IDLE;
                cnt_d    = '0;
                btn_db_d = 1'b0;
            end
        endcase

        repeating_d = (state_d == REPEAT);
    end

    assign bus.step      = step_q;
    assign bus.btn_db    = btn_db_q;
    assign bus.repeating = repeating_q;

endmodule
